clock_set_scheduler: RTL
========================

Name: clock_set_scheduler

Overview:
- Sequences the desk clock's 1 Hz tick divider and the time-set buttons.
- Normal run: passes divider overflow pulses through as seconds increments.
- While a set button is held: freezes the 1 Hz divider and generates minute or hour increment pulses with an auto-repeat that accelerates. The repeat timing is taken from a second, faster divider's overflow strobe.
- On release: resynchronises the 1 Hz divider so seconds restart cleanly.

Parameters:
- HOLD_DELAY, 8, fast strobes after the first increment before auto-repeat starts.
- RPT_DIV, 4, fast strobes between increments in slow-repeat phase.
- ACCEL_COUNT, 8, slow-repeat increments issued before switching to fast repeat.
- CNT_W, 8, width of the internal strobe and repeat counters. All parameters must be < 2^CNT_W.

Ports:
- i_sysclk  input  1  system clock.
- i_reset_n  input  1  reset, asynchronous, active-low.
- i_sec_stb  input  1  1-cycle overflow pulse from the 1 Hz divider.
- i_fast_stb  input  1  1-cycle overflow pulse from the fast (~16 Hz) divider.
- i_set_hr  input  1  hour-set button level; already synchronised and debounced.
- i_set_min  input  1  minute-set button level; already synchronised and debounced.
- o_slow_en  output  1  enable to the 1 Hz divider.
- o_slow_rst_n  output  1  synchronous reset to the 1 Hz divider; active-low.
- o_inc_sec  output  1  1-cycle seconds increment pulse.
- o_inc_min  output  1  1-cycle minutes increment pulse.
- o_inc_hr  output  1  1-cycle hours increment pulse.
- o_clr_sec  output  1  1-cycle pulse to clear the seconds counter.
- o_setting  output  1  high while in any set state.

Behaviour:
- Clock and reset: one clock, i_sysclk. Reset is asynchronous and active-low on i_reset_n.
- Registered outputs: all outputs are registered, with 1-cycle latency from the deciding input.
- Reset values: state RUN, counters 0, o_slow_en=1, o_slow_rst_n=1, o_inc_*=0, o_clr_sec=0, o_setting=0.
- States: RUN, PRESS, HOLD, REPEAT, FAST, RELEASE. Internal signals: target register tgt (HR or MIN), fast-strobe counter fcnt, repeat counter rcnt.
- RUN:
  - o_slow_en=1. o_inc_sec = i_sec_stb delayed one cycle.
  - If i_set_hr or i_set_min is high: latch tgt (HR wins when both are high) and go to PRESS.
  - i_sec_stb in that same cycle still produces o_inc_sec.
- PRESS (1 cycle):
  - Issue one increment pulse on the tgt output.
  - If tgt=MIN, pulse o_clr_sec in the same cycle.
  - Clear fcnt and rcnt, then go to HOLD.
- HOLD:
  - Count i_fast_stb into fcnt.
  - When fcnt reaches HOLD_DELAY on a strobe: issue an increment, clear fcnt, go to REPEAT.
- REPEAT:
  - Every RPT_DIV strobes: issue an increment, clear fcnt, increment rcnt.
  - The increment that makes rcnt == ACCEL_COUNT moves the block to FAST.
- FAST: issue an increment on every i_fast_stb.
- All set states (PRESS, HOLD, REPEAT, FAST):
  - o_slow_en=0 and o_setting=1.
  - i_sec_stb is ignored; no o_inc_sec is produced.
  - Only the latched button is monitored. Changes on the other button are ignored.
- Release: the latched button going low in any set state moves to RELEASE. Release has priority over a simultaneous i_fast_stb, so no increment is issued in that cycle.
- RELEASE (1 cycle):
  - o_slow_rst_n=0, o_slow_en=0, o_setting=0. Then go to RUN.
  - If the other button is still high in RUN, a new PRESS with the new tgt begins on the next cycle.
- Increment pulses: at most one per cycle, never two outputs in the same cycle, never on consecutive cycles except PRESS followed by a HOLD_DELAY=0 configuration.
- i_fast_stb in the RUN→PRESS transition cycle and in the PRESS cycle is not counted.
- Counter widths: fcnt and rcnt saturate and never wrap. rcnt stops counting in FAST.
- Mid-operation reset: asserting i_reset_n low in any state immediately forces reset values. No pulse completes.

Test Plan:
- Reset, then RUN with i_sec_stb pulsed every 10 cycles → o_inc_sec pulses 1 cycle later each time, o_slow_en=1, no min/hr pulses.
- Tap i_set_min for 3 cycles with no fast strobes → exactly one o_inc_min and one o_clr_sec, o_slow_en low for 4 cycles, one o_slow_rst_n low pulse, then RUN.
- Hold i_set_hr with i_fast_stb every 4 cycles, defaults → increments at 1 (PRESS), after 8 strobes, then 8 increments every 4 strobes, then one per strobe. Counting the PRESS increment, 18 o_inc_hr total after 48 strobes.
- Assert i_set_hr and i_set_min in the same cycle → only o_inc_hr. Release hr while min is still held → RELEASE, then PRESS with o_inc_min and o_clr_sec.
- Release the button in the same cycle as i_fast_stb during FAST → no increment, RELEASE entered. Also: i_sec_stb during set → no o_inc_sec.
- Assert i_reset_n low mid-REPEAT → outputs at reset values asynchronously. On deassertion the block is in RUN with o_slow_en=1; it re-enters PRESS if the button is still held.

Source files
------------

// File: rtl/clock_set_scheduler.sv
// Desk clock time-set sequencer: passes 1 Hz ticks through as seconds increments, and while a
// set button is held issues minute/hour increments with an accelerating auto-repeat.
module clock_set_scheduler #(
   parameter int unsigned HOLD_DELAY  = 8,
   parameter int unsigned RPT_DIV     = 4,
   parameter int unsigned ACCEL_COUNT = 8,
   parameter int unsigned CNT_W       = 8
) (
   input  logic i_sysclk,
   input  logic i_reset_n,
   input  logic i_sec_stb,
   input  logic i_fast_stb,
   input  logic i_set_hr,
   input  logic i_set_min,
   output logic o_slow_en,
   output logic o_slow_rst_n,
   output logic o_inc_sec,
   output logic o_inc_min,
   output logic o_inc_hr,
   output logic o_clr_sec,
   output logic o_setting
);

   localparam logic [2:0] ST_RUN     = 3'd0;
   localparam logic [2:0] ST_PRESS   = 3'd1;
   localparam logic [2:0] ST_HOLD    = 3'd2;
   localparam logic [2:0] ST_REPEAT  = 3'd3;
   localparam logic [2:0] ST_FAST    = 3'd4;
   localparam logic [2:0] ST_RELEASE = 3'd5;

   localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_DELAY);
   localparam logic [CNT_W-1:0] RPT_C   = CNT_W'(RPT_DIV);
   localparam logic [CNT_W-1:0] ACCEL_C = CNT_W'(ACCEL_COUNT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [2:0]       state_q, state_d;
   logic             tgt_hr_q, tgt_hr_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic             slow_en_q, slow_en_d;
   logic             slow_rst_n_q, slow_rst_n_d;
   logic             inc_sec_q, inc_sec_d;
   logic             inc_min_q, inc_min_d;
   logic             inc_hr_q, inc_hr_d;
   logic             clr_sec_q, clr_sec_d;
   logic             setting_q, setting_d;

   logic             btn_held;
   logic             fire;
   logic [CNT_W-1:0] fcnt_inc;
   logic [CNT_W-1:0] rcnt_inc;

   // Only the button latched at press time is watched; the other one is ignored until RUN.
   assign btn_held = tgt_hr_q ? i_set_hr : i_set_min;
   assign fcnt_inc = (fcnt_q == CNT_MAX) ? fcnt_q : fcnt_q + CNT_W'(1);
   assign rcnt_inc = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_W'(1);

   always_comb begin
      // NOTE: every _d signal gets a default first so no branch can infer a latch.
      state_d      = state_q;
      tgt_hr_d     = tgt_hr_q;
      fcnt_d       = fcnt_q;
      rcnt_d       = rcnt_q;
      slow_en_d    = 1'b0;
      slow_rst_n_d = 1'b1;
      inc_sec_d    = 1'b0;
      setting_d    = 1'b1;
      fire         = 1'b0;

      case (state_q)
         ST_RUN: begin
            slow_en_d = 1'b1;
            setting_d = 1'b0;
            inc_sec_d = i_sec_stb;
            if (i_set_hr || i_set_min) begin
               tgt_hr_d = i_set_hr;
               state_d  = ST_PRESS;
            end
         end

         ST_PRESS: begin
            fire    = 1'b1;
            fcnt_d  = '0;
            rcnt_d  = '0;
            state_d = btn_held ? ST_HOLD : ST_RELEASE;
         end

         ST_HOLD: begin
            if (!btn_held) begin
               state_d = ST_RELEASE;
            end else if ((HOLD_C == '0) || (i_fast_stb && (fcnt_inc >= HOLD_C))) begin
               fire    = 1'b1;
               fcnt_d  = '0;
               state_d = ST_REPEAT;
            end else if (i_fast_stb) begin
               fcnt_d = fcnt_inc;
            end
         end

         ST_REPEAT: begin
            if (!btn_held) begin
               state_d = ST_RELEASE;
            end else if (i_fast_stb) begin
               if (fcnt_inc >= RPT_C) begin
                  fire   = 1'b1;
                  fcnt_d = '0;
                  rcnt_d = rcnt_inc;
                  if (rcnt_inc >= ACCEL_C) state_d = ST_FAST;
               end else begin
                  fcnt_d = fcnt_inc;
               end
            end
         end

         ST_FAST: begin
            if (!btn_held) state_d = ST_RELEASE;
            else if (i_fast_stb) fire = 1'b1;
         end

         ST_RELEASE: begin
            slow_rst_n_d = 1'b0;
            setting_d    = 1'b0;
            state_d      = ST_RUN;
         end

         default: begin
            slow_en_d = 1'b1;
            setting_d = 1'b0;
            state_d   = ST_RUN;
         end
      endcase
   end

   assign inc_min_d = fire & ~tgt_hr_q;
   assign inc_hr_d  = fire & tgt_hr_q;
   assign clr_sec_d = fire & ~tgt_hr_q & (state_q == ST_PRESS);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_sysclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_RUN;
         tgt_hr_q     <= 1'b0;
         fcnt_q       <= '0;
         rcnt_q       <= '0;
         slow_en_q    <= 1'b1;
         slow_rst_n_q <= 1'b1;
         inc_sec_q    <= 1'b0;
         inc_min_q    <= 1'b0;
         inc_hr_q     <= 1'b0;
         clr_sec_q    <= 1'b0;
         setting_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_hr_q     <= tgt_hr_d;
         fcnt_q       <= fcnt_d;
         rcnt_q       <= rcnt_d;
         slow_en_q    <= slow_en_d;
         slow_rst_n_q <= slow_rst_n_d;
         inc_sec_q    <= inc_sec_d;
         inc_min_q    <= inc_min_d;
         inc_hr_q     <= inc_hr_d;
         clr_sec_q    <= clr_sec_d;
         setting_q    <= setting_d;
      end
   end

   assign o_slow_en    = slow_en_q;
   assign o_slow_rst_n = slow_rst_n_q;
   assign o_inc_sec    = inc_sec_q;
   assign o_inc_min    = inc_min_q;
   assign o_inc_hr     = inc_hr_q;
   assign o_clr_sec    = clr_sec_q;
   assign o_setting    = setting_q;

endmodule
